// File: rtl/pal_cfg_pkg.sv
// pal_cfg_pkg: shared state encoding, CRC constants and the bitwise CRC-8 step.
package pal_cfg_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CRC, S_DONE, S_ERR} state_t;
   localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;
   function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b, input logic [7:0] poly);
      return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? poly : 8'h00);
   endfunction
endpackage

// File: rtl/pal_cfg_serializer.sv
// pal_cfg_serializer: captures one byte and shifts it MSB-first over the next 8 cycles.
module pal_cfg_serializer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       flush,
   input  logic [7:0] data,
   output logic       chain_sdo,
   output logic       chain_shift_en,
   output logic       byte_done
);
   logic [7:0] sr_q, sr_d;
   logic [2:0] idx_q, idx_d;
   logic       act_q, act_d;
   always_comb begin
      sr_d  = sr_q;
      idx_d = idx_q;
      act_d = act_q;
      if (flush) begin
         sr_d  = '0;
         idx_d = '0;
         act_d = 1'b0;
      end else if (load) begin
         sr_d  = data;
         idx_d = '0;
         act_d = 1'b1;
      end else if (act_q) begin
         sr_d  = {sr_q[6:0], 1'b0};
         idx_d = idx_q + 3'd1;
         act_d = idx_q != 3'd7;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         idx_q <= '0;
         act_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         idx_q <= idx_d;
         act_q <= act_d;
      end
   end
   assign chain_sdo      = sr_q[7];
   assign chain_shift_en = act_q;
   assign byte_done      = act_q && (idx_q == 3'd7);
endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: loads the PAL fuse chain from a byte stream, verifies a trailing CRC-8
// and enables the PAL only after a clean load.
module pal_cfg_loader import pal_cfg_pkg::*; #(
   parameter int         CHAIN_LEN = 256,
   parameter int         CNT_W     = $clog2(CHAIN_LEN + 1),
   parameter logic [7:0] CRC_POLY  = CRC_POLY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_start,
   input  logic       cfg_abort,
   input  logic [7:0] cfg_data,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   output logic       chain_clr,
   output logic       chain_sdo,
   output logic       chain_shift_en,
   output logic       pal_enable,
   output logic       cfg_busy,
   output logic       cfg_done,
   output logic       cfg_err,
   output logic [7:0] crc_out
);
   state_t           state_q, state_d;
   logic [7:0]       crc_q, crc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             clr_q, clr_d;
   logic             accept, byte_done;
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign accept  = cfg_valid && (state_q == S_LOAD) && !cfg_start && !cfg_abort;
   pal_cfg_serializer u_ser (
      .clk           (clk),
      .rst           (rst),
      .load          (accept),
      .flush         (cfg_start || cfg_abort),
      .data          (cfg_data),
      .chain_sdo     (chain_sdo),
      .chain_shift_en(chain_shift_en),
      .byte_done     (byte_done)
   );
   // Abort outranks start; the CRC byte is compared, never shifted into the chain.
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      clr_d   = 1'b0;
      if (cfg_abort) begin
         state_d = S_IDLE;
      end else if (cfg_start) begin
         state_d = S_LOAD;
         crc_d   = CRC_INIT;
         cnt_d   = '0;
         clr_d   = 1'b1;
      end else if (chain_shift_en) begin
         crc_d = crc8_bit(crc_q, chain_sdo, CRC_POLY);
         cnt_d = cnt_inc;
         if (byte_done) state_d = (cnt_inc == CNT_W'(CHAIN_LEN)) ? S_CRC : S_LOAD;
      end else if (cfg_valid && state_q == S_CRC) begin
         state_d = (cfg_data == crc_q) ? S_DONE : S_ERR;
      end else if (accept) begin
         state_d = S_SHIFT;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         crc_q   <= CRC_INIT;
         cnt_q   <= '0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
      end
   end
   assign cfg_ready  = (state_q == S_LOAD) || (state_q == S_CRC);
   assign chain_clr  = clr_q;
   assign pal_enable = state_q == S_DONE;
   assign cfg_done   = state_q == S_DONE;
   assign cfg_err    = state_q == S_ERR;
   assign cfg_busy   = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CRC);
   assign crc_out    = crc_q;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: directed bench for two loader instances (16-bit and 8-bit chains)
// with a scoreboard of expected serial bits per instance.
module tb_pal_cfg_loader;
   logic       clk, rst;
   logic [1:0] start, abort, vld, rdy, clr, sdo, sen, pen, busy, done, err;
   logic [7:0] dat [2];
   logic [7:0] crc [2];
   int         checks = 0, errors = 0, ns0 = 0, ns1 = 0;
   bit         q0[$], q1[$];

   pal_cfg_loader #(.CHAIN_LEN(16)) u16 (
      .clk(clk), .rst(rst), .cfg_start(start[0]), .cfg_abort(abort[0]), .cfg_data(dat[0]),
      .cfg_valid(vld[0]), .cfg_ready(rdy[0]), .chain_clr(clr[0]), .chain_sdo(sdo[0]),
      .chain_shift_en(sen[0]), .pal_enable(pen[0]), .cfg_busy(busy[0]), .cfg_done(done[0]),
      .cfg_err(err[0]), .crc_out(crc[0]));
   pal_cfg_loader #(.CHAIN_LEN(8)) u8 (
      .clk(clk), .rst(rst), .cfg_start(start[1]), .cfg_abort(abort[1]), .cfg_data(dat[1]),
      .cfg_valid(vld[1]), .cfg_ready(rdy[1]), .chain_clr(clr[1]), .chain_sdo(sdo[1]),
      .chain_shift_en(sen[1]), .pal_enable(pen[1]), .cfg_busy(busy[1]), .cfg_done(done[1]),
      .cfg_err(err[1]), .crc_out(crc[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs(input int i);
      return 32'({clr[i], sdo[i], sen[i], pen[i], busy[i], done[i], err[i], rdy[i], crc[i]});
   endfunction

   always @(negedge clk) begin
      bit b;
      if (sen[0]) begin
         ns0++;
         chk("ready_in_burst0", 32'(rdy[0]), 0);
         if (q0.size() == 0) chk("sb_underflow0", 1, 0);
         else begin b = q0.pop_front(); chk("sdo0", 32'(sdo[0]), 32'(b)); end
      end
      if (sen[1]) begin
         ns1++;
         chk("ready_in_burst1", 32'(rdy[1]), 0);
         if (q1.size() == 0) chk("sb_underflow1", 1, 0);
         else begin b = q1.pop_front(); chk("sdo1", 32'(sdo[1]), 32'(b)); end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input int i, input logic [7:0] b);
      for (int k = 7; k >= 0; k--) if (i == 0) q0.push_back(b[k]); else q1.push_back(b[k]);
   endtask

   task automatic pulse_start(input int i);
      start[i] = 1'b1; tick(1); start[i] = 1'b0;
   endtask

   task automatic wait_ready(input int i);
      int k = 0;
      while (!rdy[i] && k < 40) begin tick(1); k++; end
      if (!rdy[i]) chk("ready_timeout", 0, 1);
   endtask

   task automatic send(input int i, input logic [7:0] b, input bit is_crc);
      dat[i] = b; vld[i] = 1'b1;
      wait_ready(i);
      if (!is_crc) push(i, b);
      tick(1);
      vld[i] = 1'b0;
   endtask

   initial begin
      int last, acc, snap;
      rst = 1'b1; start = '0; abort = '0; vld = '0; dat[0] = '0; dat[1] = '0;
      // reset held with inputs toggling
      for (int n = 0; n < 4; n++) begin
         start = 2'($urandom); abort = 2'($urandom); vld = 2'($urandom);
         dat[0] = 8'($urandom); dat[1] = 8'($urandom);
         @(negedge clk);
         chk("rst_outs0", outs(0), 0);
         chk("rst_outs1", outs(1), 0);
      end
      start = '0; abort = '0; vld = 2'b11;
      @(posedge clk); #1 rst = 1'b0;
      tick(2);
      chk("idle_ready0", 32'(rdy[0]), 0);
      chk("idle_busy0", 32'(busy[0]), 0);
      vld = '0;
      // good load on the 16-bit chain
      pulse_start(0);
      chk("start_clr", 32'(clr[0]), 1);
      chk("start_busy", 32'(busy[0]), 1);
      send(0, 8'h01, 0);
      wait_ready(0);
      chk("burst1_len", ns0, 8);
      send(0, 8'h00, 0);
      wait_ready(0);
      chk("burst2_len", ns0, 16);
      chk("crc16", 32'(crc[0]), 32'h15);
      send(0, 8'h15, 1);
      chk("good_done", 32'(done[0]), 1);
      chk("good_pen", 32'(pen[0]), 1);
      chk("good_crc", 32'(crc[0]), 32'h15);
      // restart from DONE, then bad CRC
      pulse_start(0);
      chk("restart_pen", 32'(pen[0]), 0);
      chk("restart_clr", 32'(clr[0]), 1);
      chk("restart_crc", 32'(crc[0]), 0);
      tick(1);
      chk("clr_one_cycle", 32'(clr[0]), 0);
      send(0, 8'h01, 0);
      send(0, 8'h00, 0);
      send(0, 8'h16, 1);
      chk("bad_err", 32'(err[0]), 1);
      chk("bad_pen", 32'(pen[0]), 0);
      chk("bad_done", 32'(done[0]), 0);
      pulse_start(0);
      chk("err_start_clr", 32'(clr[0]), 1);
      chk("err_start_busy", 32'(busy[0]), 1);
      chk("err_start_err", 32'(err[0]), 0);
      // single byte on the 8-bit chain
      pulse_start(1);
      send(1, 8'h01, 0);
      wait_ready(1);
      chk("crc8", 32'(crc[1]), 32'h07);
      send(1, 8'h07, 1);
      chk("single_done", 32'(done[1]), 1);
      // throughput with valid held high: two data bytes then CRC 00
      pulse_start(0);
      for (int k = 0; k < 16; k++) q0.push_back(1'b0);
      dat[0] = 8'h00; vld[0] = 1'b1; last = -1; acc = 0;
      for (int c = 0; c < 40; c++) begin
         if (rdy[0]) begin
            if (last >= 0) chk("accept_gap", 32'(c - last >= 9), 1);
            last = c; acc++;
         end
         tick(1);
      end
      vld[0] = 1'b0;
      chk("accept_count", acc, 3);
      chk("held_done", 32'(done[0]), 1);
      // abort on the 3rd shifted bit
      pulse_start(0);
      snap = ns0;
      send(0, 8'hAA, 0);
      tick(2);
      abort[0] = 1'b1; tick(1); abort[0] = 1'b0;
      chk("abort_sen", 32'(sen[0]), 0);
      chk("abort_busy", 32'(busy[0]), 0);
      chk("abort_pen", 32'(pen[0]), 0);
      chk("abort_shifts", ns0 - snap, 3);
      q0.delete();
      tick(2);
      chk("abort_no_more", ns0 - snap, 3);
      pulse_start(0);
      abort[0] = 1'b1; start[0] = 1'b1; tick(1); abort[0] = 1'b0; start[0] = 1'b0;
      chk("abort_start_busy", 32'(busy[0]), 0);
      chk("abort_start_clr", 32'(clr[0]), 0);
      // restart the 8-bit instance from DONE
      pulse_start(1);
      chk("r8_pen", 32'(pen[1]), 0);
      chk("r8_clr", 32'(clr[1]), 1);
      chk("r8_crc", 32'(crc[1]), 0);
      // asynchronous reset mid-load
      pulse_start(0);
      send(0, 8'hFF, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst0", outs(0), 0);
      chk("async_rst1", outs(1), 0);
      q0.delete(); q1.delete();
      @(posedge clk); #1 rst = 1'b0;
      tick(1);
      chk("post_rst_busy", 32'(busy[0]), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
Configuration controller for the PAL fuse array in the tt_um PAL top wrapper. It accepts a fuse bitstream as bytes over a valid/ready port driven from the dedicated input pins and serialises it MSB-first into the PAL's fuse shift chain. It checks a trailing CRC-8 and releases the PAL (pal_enable) only after a complete, error-free load. The PAL's outputs are gated off at all other times.

Parameters:
CHAIN_LEN, 256, fuse chain length in bits; must be a multiple of 8 and at least 8.
CNT_W, $clog2(CHAIN_LEN+1), width of the shifted-bit counter.
CRC_POLY, 8'h07, CRC-8 polynomial; init value 8'h00, no reflection, no final XOR.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
cfg_start  in  1  single-cycle pulse; begins a new load from any state.
cfg_abort  in  1  single-cycle pulse; cancels the load and returns to IDLE.
cfg_data  in  8  configuration byte, or the CRC byte.
cfg_valid  in  1  cfg_data valid.
cfg_ready  out  1  loader can accept a byte.
chain_clr  out  1  one-cycle pulse that clears the fuse chain at load start.
chain_sdo  out  1  serial fuse data to the chain.
chain_shift_en  out  1  chain shifts in chain_sdo on this cycle.
pal_enable  out  1  PAL outputs enabled; high only in DONE.
cfg_busy  out  1  high in LOAD, SHIFT and CRC.
cfg_done  out  1  high in DONE.
cfg_err  out  1  high in ERR.
crc_out  out  8  running CRC register, for debug.

Behaviour:
- Reset: state=IDLE. All outputs are 0, crc_out=8'h00, and the bit counter is 0.
- States: IDLE, LOAD, SHIFT, CRC, DONE, ERR. All outputs are registered or decoded from the state only; there is no combinational path from input to output.
- Start (any state): on cfg_start the next state is LOAD. In the same edge: chain_clr pulses for 1 cycle, CRC is reset to 8'h00, the counter is reset to 0, and pal_enable drops.
- LOAD: cfg_ready=1. On cfg_valid&&cfg_ready, capture the byte into the shift register and go to SHIFT.
- SHIFT: cfg_ready=0. For exactly 8 consecutive cycles, starting the cycle after acceptance:
  - chain_shift_en=1 and chain_sdo = current MSB;
  - the CRC is updated bitwise with that bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0);
  - the counter increments.
- After the 8th bit:
  - if counter==CHAIN_LEN, go to CRC; otherwise go to LOAD.
  - cfg_ready reasserts the cycle after the 8th shift, giving 9 cycles per byte minimum.
- CRC: cfg_ready=1. The accepted byte is not shifted. It is compared with crc. Match goes to DONE; mismatch goes to ERR.
- DONE: pal_enable=1 and cfg_done=1. The state is held until cfg_start, cfg_abort or rst.
- ERR: cfg_err=1 and pal_enable=0. The state is held until cfg_start, cfg_abort or rst.
- Abort: cfg_abort in any state goes to IDLE and clears done, err and pal_enable. The partially loaded chain contents are left as is.
- Priority: rst > cfg_abort > cfg_start > data handshake. If abort and start arrive in the same cycle, the result is IDLE.
- A cfg_start during SHIFT truncates the byte immediately. chain_shift_en is low from the next cycle.
- cfg_valid in IDLE, SHIFT, DONE or ERR is ignored; cfg_ready is low in those states.
- The counter never wraps. CNT_W holds CHAIN_LEN exactly.

Decomposition:
- Package pal_cfg_pkg holds:
  - the state enum type (3 bits);
  - CRC_POLY_DEFAULT and CRC_INIT constants;
  - the function crc8_bit(crc, bit, poly) returning 8 bits.
- One sub-module, pal_cfg_serializer, holds:
  - the 8-bit capture/shift register and the 3-bit bit index;
  - the outputs chain_sdo, chain_shift_en and a byte_done pulse.
- The FSM, counter and CRC live in pal_cfg_loader.

Test Plan:
1. Reset: with rst high and all inputs toggling, every output stays 0. After release, still IDLE with cfg_ready=0.
2. Good load, CHAIN_LEN=16:
   - start, then bytes 8'h01 and 8'h00, then CRC 8'h15;
   - chain_sdo sequence is 0000000100000000, with 16 shift_en cycles in two bursts of 8;
   - cfg_ready is low during each burst;
   - result: cfg_done=1, pal_enable=1, crc_out=8'h15.
3. Bad CRC, CHAIN_LEN=16: same bytes, then CRC 8'h16. Result: cfg_err=1, pal_enable=0. A following start gives chain_clr=1 and cfg_busy=1.
4. Single byte, CHAIN_LEN=8: byte 8'h01 gives crc_out=8'h07. Sending CRC 8'h07 reaches DONE. Throughput check: a held cfg_valid accepts bytes no faster than once per 9 cycles.
5. Abort mid-SHIFT (3rd bit): chain_shift_en is low the next cycle, state is IDLE, pal_enable=0. Abort and start in the same cycle also give IDLE.
6. Restart from DONE: cfg_start drops pal_enable the next cycle, pulses chain_clr, and resets crc_out to 8'h00. Async rst asserted mid-load clears all outputs without waiting for a clock edge.
